jac1_uart_tx: RTL and testbench

JAC1_UART_TX -- requirements
Module: jac1_uart_tx

---
 rtl/jac1_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_jac1_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jac1_uart_tx.sv
// Change-triggered UART transmitter: sends reg_val as an 8N1 frame whenever it differs from the last seen value.
// Define JAC1_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module jac1_uart_tx #(
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 sys_res_n,
  input  logic [DataWidth-1:0] reg_val,
  output logic                 tx,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef JAC1_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);

  state_t               state_q, state_n;
  logic [15:0]          cnt_q, cnt_n;
  logic [2:0]           idx_q, idx_n;
  logic [DataWidth-1:0] data_q, data_n;
  logic [DataWidth-1:0] pbuf_q, pbuf_n;
  logic [DataWidth-1:0] last_q;
  logic                 pend_q, pend_n;
  logic                 ovr_n;
  logic                 tx_n;
  logic                 busy_n;
  logic                 change;
  logic                 bit_done;

  assign change   = (reg_val != last_q);
  assign bit_done = (cnt_q == BitLast);

  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pbuf_q  <= '0;
      last_q  <= '0;
      pend_q  <= 1'b0;
      overrun <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      pbuf_q  <= pbuf_n;
      last_q  <= reg_val;
      pend_q  <= pend_n;
      overrun <= ovr_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 16'd1;
    idx_n   = idx_q;
    data_n  = data_q;
    pbuf_n  = pbuf_q;
    pend_n  = pend_q;
    ovr_n   = overrun;

    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (change) begin
          data_n  = reg_val;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          idx_n = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef JAC1_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef JAC1_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (pend_q) begin
            data_n  = pbuf_q;
            pend_n  = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    // On the final stop cycle the frame slot is freeing up, so a change either
    // starts straight away (nothing pending) or queues behind the pending value.
    if (change && (state_q != IDLE)) begin
      if ((state_q == STOP) && bit_done) begin
        if (!pend_q) begin
          data_n  = reg_val;
          state_n = START;
        end else begin
          pbuf_n = reg_val;
          pend_n = 1'b1;
        end
      end else begin
        pbuf_n = reg_val;
        pend_n = 1'b1;
        if (pend_q) begin
          ovr_n = 1'b1;
        end
      end
    end
  end

  // tx and busy are registered from the next state so the line moves on the same edge as the FSM.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    unique case (state_n)
      IDLE:   tx_n = 1'b1;
      START:  tx_n = 1'b0;
      DATA:   tx_n = data_n[idx_n];
`ifdef JAC1_UART_PARITY_EN
      PARITY: tx_n = ^data_n;
`endif
      STOP:   tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_jac1_uart_tx.sv
// Scoreboard bench for jac1_uart_tx (default build, no parity) with CLKS_PER_BIT=4.
module tb_jac1_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       sys_res_n;
  logic [7:0] reg_val;
  logic       tx;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       frame_abort = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_stop;
  int         busy_run  = 0;
  int         busy_last = 0;
  int         idle_bad;
  logic [7:0] pats[4] = '{8'h3C, 8'hFF, 8'h01, 8'h80};

  jac1_uart_tx #(.DataWidth(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .sys_res_n (sys_res_n),
    .reg_val   (reg_val),
    .tx        (tx),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_res_n) frame_abort = 1'b1;

  // Length of the most recent continuous busy-high run, in clocks.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) busy_last <= busy_run;
      busy_run <= 0;
    end
  end

  // Line decoder: samples each bit on its second cycle and scores the frame.
  initial begin
    forever begin
      @(negedge clk);
      if (sys_res_n === 1'b1 && tx === 1'b0) begin
        frame_abort = 1'b0;
        repeat (CPB + 1) @(negedge clk);
        rx_byte[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_stop = tx;
        repeat (CPB - 2) @(negedge clk);
        if (!frame_abort) begin
          check_eq("stop_bit", {31'd0, rx_stop}, 32'd1);
          if (exp_q.size() == 0) check_eq("frame_unexpected", exp_q.size(), 32'd1);
          else check_eq("frame", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_idle_timeout", (n >= 2000) ? 32'd1 : 32'd0, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic count_idle(input int cycles);
    idle_bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
  endtask

  initial begin
    sys_res_n = 1'b0;
    reg_val   = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovr", {31'd0, overrun}, 32'd0);
    sys_res_n = 1'b1;

    count_idle(100);
    check_eq("steady_zero_idle", idle_bad, 32'd0);

    // Single frame with latency check
    @(negedge clk);
    check_eq("pre_tx", {31'd0, tx}, 32'd1);
    reg_val = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    check_eq("lat_tx", {31'd0, tx}, 32'd0);
    check_eq("lat_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check_eq("busy_len_a5", busy_last, 32'd40);
    check_eq("ovr_a5", {31'd0, overrun}, 32'd0);

    foreach (pats[k]) begin
      @(negedge clk);
      reg_val = pats[k];
      exp_q.push_back(pats[k]);
      wait_idle();
      check_eq("busy_len_pat", busy_last, 32'd40);
    end

    // Overwrite of a pending value: 0x22 is lost, overrun sticks
    @(negedge clk);
    reg_val = 8'h11;
    exp_q.push_back(8'h11);
    repeat (10) @(negedge clk);
    reg_val = 8'h22;
    repeat (10) @(negedge clk);
    reg_val = 8'h33;
    exp_q.push_back(8'h33);
    wait_idle();
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    check_eq("busy_len_b2b", busy_last, 32'd80);

    // Reset in the middle of the data bits
    @(negedge clk);
    reg_val = 8'h44;
    exp_q.push_back(8'h44);
    repeat (15) @(negedge clk);
    reg_val   = 8'h00;
    sys_res_n = 1'b0;
    #1;
    check_eq("midrst_tx", {31'd0, tx}, 32'd1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_ovr", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    sys_res_n = 1'b1;
    count_idle(40);
    check_eq("post_rst_idle", idle_bad, 32'd0);

    // Nonzero value present at reset release starts a frame
    sys_res_n = 1'b0;
    reg_val   = 8'h80;
    @(negedge clk);
    exp_q.push_back(8'h80);
    sys_res_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_start_tx", {31'd0, tx}, 32'd0);
    wait_idle();
    check_eq("busy_len_rel", busy_last, 32'd40);

    // Change on the final stop cycle with nothing pending
    @(negedge clk);
    reg_val = 8'h01;
    exp_q.push_back(8'h01);
    repeat (40) @(negedge clk);
    reg_val = 8'h5A;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    check_eq("stopedge_tx", {31'd0, tx}, 32'd0);
    check_eq("stopedge_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check_eq("busy_len_stopedge", busy_last, 32'd80);
    check_eq("ovr_stopedge", {31'd0, overrun}, 32'd0);

    // Change on the final stop cycle with a value already pending
    @(negedge clk);
    reg_val = 8'h10;
    exp_q.push_back(8'h10);
    repeat (10) @(negedge clk);
    reg_val = 8'h20;
    exp_q.push_back(8'h20);
    repeat (30) @(negedge clk);
    reg_val = 8'h30;
    exp_q.push_back(8'h30);
    wait_idle();
    check_eq("busy_len_pendedge", busy_last, 32'd120);
    check_eq("ovr_pendedge", {31'd0, overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
